// File: rtl/lvds_panel_power_seq_pkg.sv
// Shared definitions for the LVDS panel power sequencer: state codes and datapath widths.
package lvds_panel_power_seq_pkg;

  localparam int STATE_W = 3;
  localparam int CNT_W   = 32;

  typedef enum logic [STATE_W-1:0] {
    ST_OFF       = 3'd0,
    ST_PWR_UP    = 3'd1,
    ST_DATA_UP   = 3'd2,
    ST_RUN       = 3'd3,
    ST_BL_DOWN   = 3'd4,
    ST_DATA_DOWN = 3'd5,
    ST_OFF_HOLD  = 3'd6
  } state_t;

endpackage

// File: rtl/lvds_panel_power_seq_sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs, cleared to 0 by reset.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] meta;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meta <= '0;
      o_q  <= '0;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/lvds_panel_power_seq.sv
// LVDS panel power sequencer: VDD -> timing generator/LVDS TX -> backlight on the way up,
// reverse order on the way down, each step held for a minimum delay.
//
//   state      | meaning
//   OFF        | everything off, waiting for enable with PLL locked
//   PWR_UP     | VDD on, generator held in reset
//   DATA_UP    | generator released, LVDS TX driving
//   RUN        | backlight on, panel ready
//   BL_DOWN    | backlight off, data still running
//   DATA_DOWN  | generator reset, TX off, VDD still on
//   OFF_HOLD   | VDD off, enforcing minimum off time
module lvds_panel_power_seq
  import lvds_panel_power_seq_pkg::*;
#(
  parameter int unsigned CLK_PER_US    = 65,
  parameter int unsigned T_VDD_DATA_US = 20000,
  parameter int unsigned T_DATA_BL_US  = 200000,
  parameter int unsigned T_BL_DATA_US  = 200000,
  parameter int unsigned T_DATA_VDD_US = 20000,
  parameter int unsigned T_OFF_MIN_US  = 500000
) (
  input  logic               i_clk_65mhz,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic               i_pll_locked,
  output logic               o_vdd_en,
  output logic               o_gen_rst,
  output logic               o_tx_en,
  output logic               o_bl_en,
  output logic               o_ready,
  output logic               o_fault,
  output logic [STATE_W-1:0] o_state
);

  localparam logic [CNT_W-1:0] LIM_VDD_DATA = CNT_W'(T_VDD_DATA_US * CLK_PER_US - 1);
  localparam logic [CNT_W-1:0] LIM_DATA_BL  = CNT_W'(T_DATA_BL_US * CLK_PER_US - 1);
  localparam logic [CNT_W-1:0] LIM_BL_DATA  = CNT_W'(T_BL_DATA_US * CLK_PER_US - 1);
  localparam logic [CNT_W-1:0] LIM_DATA_VDD = CNT_W'(T_DATA_VDD_US * CLK_PER_US - 1);
  localparam logic [CNT_W-1:0] LIM_OFF_MIN  = CNT_W'(T_OFF_MIN_US * CLK_PER_US - 1);

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lim;
  logic             timed;
  logic             tc;
  logic             lock_s;
  logic             fault_set;
  logic             run_q;

  sync_2ff #(.W(1)) u_lock_sync (
    .i_clk (i_clk_65mhz),
    .i_rst (i_rst),
    .i_d   (i_pll_locked),
    .o_q   (lock_s)
  );

  always_comb begin
    lim   = '0;
    timed = 1'b1;
    case (state)
      ST_PWR_UP:    lim = LIM_VDD_DATA;
      ST_DATA_UP:   lim = LIM_DATA_BL;
      ST_BL_DOWN:   lim = LIM_BL_DATA;
      ST_DATA_DOWN: lim = LIM_DATA_VDD;
      ST_OFF_HOLD:  lim = LIM_OFF_MIN;
      default:      timed = 1'b0;
    endcase
  end

  assign tc = timed && (cnt == lim);

  // Lock loss is checked first so it alone decides whether the fault is recorded.
  always_comb begin
    next_state = state;
    fault_set  = 1'b0;
    case (state)
      ST_OFF:       if (i_enable && lock_s && !o_fault) next_state = ST_PWR_UP;
      ST_PWR_UP: begin
        if (!lock_s) begin
          fault_set  = 1'b1;
          next_state = ST_DATA_DOWN;
        end else if (!i_enable) next_state = ST_DATA_DOWN;
        else if (tc)            next_state = ST_DATA_UP;
      end
      ST_DATA_UP: begin
        if (!lock_s) begin
          fault_set  = 1'b1;
          next_state = ST_BL_DOWN;
        end else if (!i_enable) next_state = ST_BL_DOWN;
        else if (tc)            next_state = ST_RUN;
      end
      ST_RUN: begin
        if (!lock_s) begin
          fault_set  = 1'b1;
          next_state = ST_BL_DOWN;
        end else if (!i_enable) next_state = ST_BL_DOWN;
      end
      ST_BL_DOWN:   if (tc) next_state = ST_DATA_DOWN;
      ST_DATA_DOWN: if (tc) next_state = ST_OFF_HOLD;
      ST_OFF_HOLD:  if (tc) next_state = ST_OFF;
      default:      next_state = ST_OFF;
    endcase
  end

  always_ff @(posedge i_clk_65mhz or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_OFF;
      cnt       <= '0;
      o_fault   <= 1'b0;
      o_vdd_en  <= 1'b0;
      o_gen_rst <= 1'b1;
      o_tx_en   <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state != state) cnt <= '0;
      else if (timed)          cnt <= cnt + 1'b1;
      if (fault_set)                        o_fault <= 1'b1;
      else if (state == ST_OFF && !i_enable) o_fault <= 1'b0;
      // Outputs decode next_state so pins move on the same edge as o_state.
      o_vdd_en  <= (next_state >= ST_PWR_UP) && (next_state <= ST_DATA_DOWN);
      o_tx_en   <= (next_state >= ST_DATA_UP) && (next_state <= ST_BL_DOWN);
      o_gen_rst <= !((next_state >= ST_DATA_UP) && (next_state <= ST_BL_DOWN));
      run_q     <= (next_state == ST_RUN);
    end
  end

  assign o_bl_en = run_q;
  assign o_ready = run_q;
  assign o_state = state;

endmodule

// File: tb/tb_lvds_panel_power_seq.sv
// Bench for lvds_panel_power_seq: directed power sequences plus random enable/lock traffic,
// all compared against a duration-table reference model.
module tb_lvds_panel_power_seq;

  localparam int unsigned CLK_PER_US = 2;
  localparam int unsigned T_VDD_DATA = 3;
  localparam int unsigned T_DATA_BL  = 4;
  localparam int unsigned T_BL_DATA  = 4;
  localparam int unsigned T_DATA_VDD = 3;
  localparam int unsigned T_OFF_MIN  = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       pll;
  logic       vdd_en, gen_rst, tx_en, bl_en, ready, fault;
  logic [2:0] state;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // reference model: state code, cycles remaining in it, fault, lock pipeline
  int       m_st;
  int       m_rem;
  bit       m_fault;
  bit [1:0] m_sync;

  always #5 clk = ~clk;

  lvds_panel_power_seq #(
    .CLK_PER_US    (CLK_PER_US),
    .T_VDD_DATA_US (T_VDD_DATA),
    .T_DATA_BL_US  (T_DATA_BL),
    .T_BL_DATA_US  (T_BL_DATA),
    .T_DATA_VDD_US (T_DATA_VDD),
    .T_OFF_MIN_US  (T_OFF_MIN)
  ) dut (
    .i_clk_65mhz  (clk),
    .i_rst        (rst),
    .i_enable     (en),
    .i_pll_locked (pll),
    .o_vdd_en     (vdd_en),
    .o_gen_rst    (gen_rst),
    .o_tx_en      (tx_en),
    .o_bl_en      (bl_en),
    .o_ready      (ready),
    .o_fault      (fault),
    .o_state      (state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic int dur(input int s);
    case (s)
      1:       return T_VDD_DATA * CLK_PER_US;
      2:       return T_DATA_BL * CLK_PER_US;
      4:       return T_BL_DATA * CLK_PER_US;
      5:       return T_DATA_VDD * CLK_PER_US;
      6:       return T_OFF_MIN * CLK_PER_US;
      default: return 0;
    endcase
  endfunction

  // packed {state, vdd, gen_rst, tx, bl, ready, fault}
  function automatic logic [8:0] model_vec();
    bit v, d, r;
    v = (m_st >= 1 && m_st <= 5);
    d = (m_st >= 2 && m_st <= 4);
    r = (m_st == 3);
    return {3'(m_st), v, !d, d, r, r, m_fault};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {state, vdd_en, gen_rst, tx_en, bl_en, ready, fault};
  endfunction

  task automatic model_reset();
    m_st = 0; m_rem = 0; m_fault = 0; m_sync = 2'b00;
  endtask

  task automatic model_step(input bit e, input bit lk);
    bit ls, abort;
    int nxt;
    ls     = m_sync[1];
    m_sync = {m_sync[0], lk};
    abort  = !e || !ls;
    nxt    = m_st;
    case (m_st)
      0: begin
        if (!e) m_fault = 0;
        else if (ls && !m_fault) nxt = 1;
      end
      1, 2: begin
        if (abort) begin
          if (!ls) m_fault = 1;
          nxt = (m_st == 1) ? 5 : 4;
        end else if (m_rem == 1) nxt = m_st + 1;
      end
      3: if (abort) begin
        if (!ls) m_fault = 1;
        nxt = 4;
      end
      4, 5: if (m_rem == 1) nxt = m_st + 1;
      6:    if (m_rem == 1) nxt = 0;
      default: nxt = 0;
    endcase
    if (nxt != m_st) begin
      m_st  = nxt;
      m_rem = dur(nxt);
    end else if (m_rem > 0) m_rem--;
  endtask

  task automatic tick(input bit e, input bit lk);
    @(negedge clk);
    en  = e;
    pll = lk;
    model_step(e, lk);
    @(posedge clk);
    #1;
    check("outs", dut_vec(), model_vec());
  endtask

  task automatic ticks(input int n, input bit e, input bit lk);
    for (int i = 0; i < n; i++) tick(e, lk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; pll = 1'b1;
    model_reset();
    #12;
    check("reset_outs", dut_vec(), {3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    ticks(3, 0, 1);

    // power-up
    tick(1, 1);
    check("pu_state1", state, 3'd1);
    check("pu_vdd", vdd_en, 1'b1);
    ticks(6, 1, 1);
    check("pu_tx_en", tx_en, 1'b1);
    check("pu_gen_rst", gen_rst, 1'b0);
    ticks(8, 1, 1);
    check("pu_run", state, 3'd3);
    check("pu_ready", ready, 1'b1);

    // normal power-down
    tick(0, 1);
    check("pd_bl_off", bl_en, 1'b0);
    ticks(8, 0, 1);
    check("pd_tx_off", tx_en, 1'b0);
    ticks(6, 0, 1);
    check("pd_vdd_off", vdd_en, 1'b0);
    ticks(10, 0, 1);
    check("pd_off", state, 3'd0);

    // abort in PWR_UP on its third cycle
    ticks(3, 1, 1);
    tick(0, 1);
    check("abort_state", state, 3'd5);
    check("abort_gen_rst", gen_rst, 1'b1);
    ticks(6, 0, 1);
    check("abort_vdd_off", vdd_en, 1'b0);
    ticks(10, 0, 1);

    // lock loss in RUN; lock returns mid-shutdown without effect
    ticks(15, 1, 1);
    check("ll_run", state, 3'd3);
    ticks(3, 1, 0);
    check("ll_fault", fault, 1'b1);
    check("ll_bl_off", bl_en, 1'b0);
    ticks(10, 1, 0);
    ticks(14, 1, 1);
    check("ll_off", state, 3'd0);
    ticks(5, 1, 1);
    check("ll_stay_off", state, 3'd0);
    check("ll_fault_sticky", fault, 1'b1);
    tick(0, 1);
    check("ll_fault_clr", fault, 1'b0);
    tick(1, 1);
    check("ll_restart", state, 3'd1);

    // restart request during OFF_HOLD
    ticks(14, 1, 1);
    tick(0, 1);
    ticks(14, 0, 1);
    check("rh_hold", state, 3'd6);
    ticks(9, 1, 1);
    check("rh_still_hold", state, 3'd6);
    tick(1, 1);
    check("rh_off", state, 3'd0);
    tick(1, 1);
    check("rh_pwr_up", state, 3'd1);
    check("rh_vdd", vdd_en, 1'b1);

    // async reset in RUN
    ticks(14, 1, 1);
    check("ar_run", state, 3'd3);
    #1 rst = 1'b1;
    #1;
    check("ar_outs", dut_vec(), {3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    model_reset();
    #1 rst = 1'b0;
    ticks(2, 1, 1);
    check("ar_sync_wait", state, 3'd0);
    tick(1, 1);
    check("ar_restart", state, 3'd1);

    // random enable / lock traffic
    begin
      bit e, lk;
      e = 1; lk = 1;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 29) == 0) e = !e;
        if (lk && $urandom_range(0, 299) == 0) lk = 0;
        else if (!lk && $urandom_range(0, 7) == 0) lk = 1;
        tick(e, lk);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/lvds_panel_power_seq.md
Name: lvds_panel_power_seq

Overview:
Power-sequencing controller for the LVDS panel path. It steps the panel through its power-up and power-down order: panel VDD, then the video timing generator and LVDS transmitter, then backlight, and the reverse on shutdown. Each step is held for a minimum delay in microseconds. It sits between board-level enable/PLL-lock signals and the timing generator reset, LVDS output enable and panel power pins.

Parameters:
CLK_PER_US, 65, clock cycles per microsecond (65 MHz pixel clock)
T_VDD_DATA_US, 20000, VDD on to generator/TX start
T_DATA_BL_US, 200000, generator/TX start to backlight on
T_BL_DATA_US, 200000, backlight off to generator/TX stop
T_DATA_VDD_US, 20000, generator/TX stop to VDD off
T_OFF_MIN_US, 500000, minimum VDD-off time before a restart
(all T_* >= 1; each product T*CLK_PER_US < 2^32)

Ports:
i_clk_65mhz  input  1  pixel clock, sole clock
i_rst  input  1  asynchronous, active-high reset
i_enable  input  1  level request: panel on (synchronous to i_clk_65mhz)
i_pll_locked  input  1  PLL lock, asynchronous; synchronised internally
o_vdd_en  output  1  panel VDD switch enable
o_gen_rst  output  1  active-high reset to the timing generator
o_tx_en  output  1  LVDS transmitter output enable
o_bl_en  output  1  backlight enable
o_ready  output  1  high in RUN only
o_fault  output  1  sticky: PLL lock lost while powered
o_state  output  3  current state code

Behaviour:
- Reset (async): state OFF, o_vdd_en=0, o_gen_rst=1, o_tx_en=0, o_bl_en=0, o_ready=0, o_fault=0, o_state=0, delay counter=0, sync flops=0.
- lock_s = i_pll_locked after a 2-flop synchroniser (2-cycle latency).
- States (code): OFF(0), PWR_UP(1), DATA_UP(2), RUN(3), BL_DOWN(4), DATA_DOWN(5), OFF_HOLD(6).
- Delay counter: 32-bit. Cleared on every state change. Increments each cycle in a timed state. The timed state exits on the cycle the counter == T*CLK_PER_US-1, so the state lasts exactly T*CLK_PER_US cycles.
- Transitions:
  - OFF->PWR_UP: i_enable & lock_s & !o_fault.
  - PWR_UP->DATA_UP: on timeout T_VDD_DATA.
  - PWR_UP->DATA_DOWN: !i_enable. The generator is never released.
  - DATA_UP->RUN: on timeout T_DATA_BL.
  - DATA_UP->BL_DOWN: !i_enable.
  - RUN->BL_DOWN: !i_enable.
  - BL_DOWN->DATA_DOWN: on timeout T_BL_DATA.
  - DATA_DOWN->OFF_HOLD: on timeout T_DATA_VDD.
  - OFF_HOLD->OFF: on timeout T_OFF_MIN.
  - In PWR_UP/DATA_UP/RUN, !lock_s sets o_fault and takes the same exit as !i_enable. Lock loss has priority; if both are true, one exit is taken.
  - Down states (4,5,6) ignore i_enable and lock_s; they always run to completion.
- Outputs are registered and decoded from next_state, so they change on the same edge as o_state:
  - o_vdd_en = state in {1..5}
  - o_gen_rst = state not in {2,3,4}
  - o_tx_en = state in {2,3,4}
  - o_bl_en = o_ready = (state==3)
- Fault clear: o_fault clears on any edge where state==OFF and i_enable==0. While o_fault=1 the block stays in OFF even with i_enable high.
- Lock regained during a down sequence has no effect.

Decomposition:
- Shared package: state code constants (OFF..OFF_HOLD), the 3-bit state width, and the delay counter width (32).
- One sub-module: sync_2ff (parameterised-width two-flop synchroniser, reset to 0 by i_rst), used for i_pll_locked.
- The FSM, delay counter and output decode stay in lvds_panel_power_seq.

Test Plan:
Bench parameters: CLK_PER_US=2, T_VDD_DATA_US=3, T_DATA_BL_US=4, T_BL_DATA_US=4, T_DATA_VDD_US=3, T_OFF_MIN_US=5, giving delays of 6/8/8/6/10 cycles. Lock held high from reset unless stated.

1. Power-up: i_enable=1 sampled at edge k -> o_vdd_en=1 and o_state=1 after edge k; o_gen_rst=0 and o_tx_en=1 after edge k+6; o_bl_en=o_ready=1 and o_state=3 after edge k+14.
2. Normal power-down: i_enable=0 sampled at edge m in RUN -> o_bl_en=0 after m; o_gen_rst=1 and o_tx_en=0 after m+8; o_vdd_en=0 after m+14; o_state=0 after m+24.
3. Abort in PWR_UP: i_enable drops at the 3rd cycle of PWR_UP -> state 5 on that edge; o_vdd_en=0 six cycles later; o_gen_rst stays 1 and o_tx_en stays 0 throughout.
4. Lock loss in RUN: i_pll_locked=0 -> o_fault=1 and o_bl_en=0 after the 3rd edge; full down sequence completes; block stays in OFF with i_enable=1. Then i_enable=0 for one edge clears o_fault, and re-asserting i_enable restarts PWR_UP.
5. Restart during hold: i_enable re-asserted on the 2nd cycle of OFF_HOLD -> 10 cycles in OFF_HOLD, 1 cycle in OFF, then PWR_UP with o_vdd_en=1.
6. Async reset mid-RUN: i_rst pulses between edges -> immediately o_vdd_en=0, o_bl_en=0, o_tx_en=0, o_gen_rst=1, o_state=0, o_fault=0; after release with i_enable=1, lock_s takes 2 edges to rise, then the sequence restarts from PWR_UP.
